vscale_mem_arbiter: RTL and testbench
=====================================

Name: vscale_mem_arbiter

Overview:
Shares one single-ported memory between the pipeline's instruction-fetch port (imem_*) and data port (dmem_*). It serialises each cycle's fetch and optional data access into valid/ready memory requests, in data-first order. It realigns the one-cycle-late store data and range-checks addresses to produce badmem exceptions. It sits between vscale_pipeline and the memory, and generates imem_wait/dmem_wait.

Parameters:
MEM_BASE, 32'h0, lowest legal byte address
MEM_SIZE, 32'h10000, legal window size in bytes; legal iff MEM_BASE <= addr < MEM_BASE+MEM_SIZE
XPR_LEN, 32, data/address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_addr  in  32  fetch address
imem_rdata  out  32  fetched instruction
imem_wait  out  1  fetch not complete
imem_badmem_e  out  1  fetch address illegal
dmem_en  in  1  data access requested this cycle
dmem_wen  in  1  store when 1, load when 0
dmem_size  in  3  0=byte, 1=half, 2=word; other values illegal
dmem_addr  in  32  data byte address
dmem_wdata_delayed  in  32  store data, valid the cycle after dmem_en
dmem_rdata  out  32  raw load word
dmem_wait  out  1  data access not complete
dmem_badmem_e  out  1  data address illegal or misaligned
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  write request
mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_req_wdata  out  32  write data
mem_req_wmask  out  4  byte enables
mem_resp_valid  in  1  response or write-ack, one per accepted request
mem_resp_rdata  in  32  read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE; mem_req_valid=0; imem_wait=dmem_wait=0; badmem flags 0; dmem_rdata=0; imem_rdata=32'h00000013 (NOP).
- States and wait outputs: IDLE, WDATA, D_REQ, D_RESP, I_REQ, I_RESP, DONE.
  - imem_wait=dmem_wait=0 in IDLE and DONE; both are 1 in every other state.
- Capture (IDLE or DONE, cycle T):
  - Register imem_addr, dmem_en, dmem_wen, dmem_size and dmem_addr.
  - Compute dbad = dmem_en & (out of range | size>2 | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0)).
  - Compute ibad = fetch out of range | imem_addr[1:0]!=0.
  - Next state, first match wins:
    - dmem_en & ~dbad & dmem_wen -> WDATA
    - dmem_en & ~dbad -> D_REQ
    - ~ibad -> I_REQ
    - otherwise -> DONE
- WDATA (T+1): latch dmem_wdata_delayed, replicated per size (byte x4, half x2); go to D_REQ. No memory request in this cycle.
- D_REQ: mem_req_valid=1 with stable addr, wen, wdata and wmask until mem_req_ready; on handshake go to D_RESP.
  - wmask: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hf. Reads drive wmask=0.
- D_RESP: wait for mem_resp_valid. On a read, latch mem_resp_rdata. Then go to I_REQ if ~ibad, else DONE.
- I_REQ / I_RESP: same as D_REQ / D_RESP with wen=0; latch the instruction; go to DONE.
- DONE (one cycle):
  - Drive the latched imem_rdata and dmem_rdata; badmem_e flags reflect the captured checks.
  - Perform a new capture in the same cycle.
  - Illegal accesses issue no memory request; their rdata reads 0.
  - Flags and rdata hold their values until the next DONE.
- Latency, zero-wait memory (ready=1, resp one cycle after accept):
  - fetch only: DONE at T+3
  - load + fetch: DONE at T+5
  - store + fetch: DONE at T+6
- At most one memory request is outstanding. mem_resp_valid outside D_RESP/I_RESP is ignored.
- mem_req_valid never drops before ready. If ready is asserted in the same cycle valid first rises, the handshake completes in that cycle.
- dmem_en=0 leaves store data unused and dmem_rdata=0 in DONE.
- Reset mid-transaction returns to IDLE at once, abandons any outstanding response, and restores reset values.

Test Plan:
- Fetch only: imem_addr=0x200, dmem_en=0, memory returns 0x00500093 -> imem_wait high for 2 cycles; DONE at T+3 with imem_rdata=0x00500093, dmem_badmem_e=0.
- Load first: dmem_en=1, wen=0, size=2, addr=0x1004, fetch 0x204 -> first request addr 0x1004 wen=0; second request 0x204; DONE at T+5 with both rdatas correct.
- Byte store: dmem_addr=0x1003, size=0, dmem_wdata_delayed=0x000000AB at T+1 -> mem_req_wdata=0xABABABAB, wmask=4'b1000, addr=0x1000.
- Misaligned half: addr=0x1001, size=1 -> no data request issued; dmem_badmem_e=1 in DONE; fetch still completes.
- Backpressure: mem_req_ready low for 4 cycles in D_REQ -> valid, addr and wdata held stable; waits held high; completes after ready.
- Async reset asserted in I_RESP -> state=IDLE immediately, waits=0, imem_rdata=0x00000013; a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/vscale_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Each capture issues the data request (if any) first, then the fetch, and reports both in DONE.
module vscale_mem_arbiter #(
  parameter int unsigned        XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0] MEM_BASE = 32'h0,
  parameter logic [XPR_LEN-1:0] MEM_SIZE = 32'h10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XPR_LEN-1:0] imem_addr,
  output logic [XPR_LEN-1:0] imem_rdata,
  output logic               imem_wait,
  output logic               imem_badmem_e,
  input  logic               dmem_en,
  input  logic               dmem_wen,
  input  logic [2:0]         dmem_size,
  input  logic [XPR_LEN-1:0] dmem_addr,
  input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
  output logic [XPR_LEN-1:0] dmem_rdata,
  output logic               dmem_wait,
  output logic               dmem_badmem_e,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_wen,
  output logic [XPR_LEN-1:0] mem_req_addr,
  output logic [XPR_LEN-1:0] mem_req_wdata,
  output logic [3:0]         mem_req_wmask,
  input  logic               mem_resp_valid,
  input  logic [XPR_LEN-1:0] mem_resp_rdata
);

  typedef enum logic [2:0] {IDLE, WDATA, D_REQ, D_RESP, I_REQ, I_RESP, DONE} state_t;

  state_t               state_q;
  logic [XPR_LEN-1:2]   ia_q, da_q_hi;
  logic [1:0]           da_q_lo;
  logic                 dwen_q;
  logic [1:0]           dsize_q;
  logic                 ibad_q, dbad_q;
  logic [XPR_LEN-1:0]   drd_q;
  logic [XPR_LEN-1:0]   imem_rdata_q, dmem_rdata_q;
  logic                 imem_bad_q, dmem_bad_q;
  logic                 req_valid_q, req_wen_q;
  logic [XPR_LEN-1:2]   req_addr_q;
  logic [XPR_LEN-1:0]   req_wdata_q;
  logic [3:0]           req_wmask_q;
  logic                 cap_dbad, cap_ibad;

  function automatic logic in_range(input logic [XPR_LEN-1:0] a);
    logic [XPR_LEN:0] lim;
    lim = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    return (a >= MEM_BASE) && ({1'b0, a} < lim);
  endfunction

  function automatic logic [XPR_LEN-1:0] replicate(input logic [1:0] sz, input logic [XPR_LEN-1:0] w);
    case (sz)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << a;
      default: return 4'hf;
    endcase
  endfunction

  always_comb begin
    cap_dbad = dmem_en & (~in_range(dmem_addr) | (dmem_size > 3'd2)
             | ((dmem_size == 3'd1) & dmem_addr[0])
             | ((dmem_size == 3'd2) & (dmem_addr[1:0] != 2'b00)));
    cap_ibad = ~in_range(imem_addr) | (imem_addr[1:0] != 2'b00);
  end

  // Store-side request fields are cleared at every data handshake, so fetch and load
  // issue only need to set valid and address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ia_q         <= '0;
      da_q_hi      <= '0;
      da_q_lo      <= '0;
      dwen_q       <= 1'b0;
      dsize_q      <= '0;
      ibad_q       <= 1'b0;
      dbad_q       <= 1'b0;
      drd_q        <= '0;
      imem_rdata_q <= 32'h00000013;
      dmem_rdata_q <= '0;
      imem_bad_q   <= 1'b0;
      dmem_bad_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      req_wen_q    <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wmask_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          ia_q    <= imem_addr[XPR_LEN-1:2];
          da_q_hi <= dmem_addr[XPR_LEN-1:2];
          da_q_lo <= dmem_addr[1:0];
          dwen_q  <= dmem_wen;
          dsize_q <= dmem_size[1:0];
          ibad_q  <= cap_ibad;
          dbad_q  <= cap_dbad;
          drd_q   <= '0;
          if (dmem_en & ~cap_dbad & dmem_wen) begin
            state_q <= WDATA;
          end else if (dmem_en & ~cap_dbad) begin
            state_q     <= D_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= dmem_addr[XPR_LEN-1:2];
          end else if (~cap_ibad) begin
            state_q     <= I_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= imem_addr[XPR_LEN-1:2];
          end else begin
            state_q      <= DONE;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_bad_q   <= cap_ibad;
            dmem_bad_q   <= cap_dbad;
          end
        end
        WDATA: begin
          state_q     <= D_REQ;
          req_valid_q <= 1'b1;
          req_wen_q   <= 1'b1;
          req_addr_q  <= da_q_hi;
          req_wdata_q <= replicate(dsize_q, dmem_wdata_delayed);
          req_wmask_q <= byte_mask(dsize_q, da_q_lo);
        end
        D_REQ: begin
          if (mem_req_ready) begin
            state_q     <= D_RESP;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
          end
        end
        D_RESP: begin
          if (mem_resp_valid) begin
            if (!dwen_q) drd_q <= mem_resp_rdata;
            if (!ibad_q) begin
              state_q     <= I_REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= ia_q;
            end else begin
              state_q      <= DONE;
              imem_rdata_q <= '0;
              dmem_rdata_q <= dwen_q ? '0 : mem_resp_rdata;
              imem_bad_q   <= ibad_q;
              dmem_bad_q   <= dbad_q;
            end
          end
        end
        I_REQ: begin
          if (mem_req_ready) begin
            state_q     <= I_RESP;
            req_valid_q <= 1'b0;
          end
        end
        I_RESP: begin
          if (mem_resp_valid) begin
            state_q      <= DONE;
            imem_rdata_q <= mem_resp_rdata;
            dmem_rdata_q <= drd_q;
            imem_bad_q   <= ibad_q;
            dmem_bad_q   <= dbad_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_wait     = (state_q != IDLE) && (state_q != DONE);
  assign dmem_wait     = imem_wait;
  assign imem_rdata    = imem_rdata_q;
  assign dmem_rdata    = dmem_rdata_q;
  assign imem_badmem_e = imem_bad_q;
  assign dmem_badmem_e = dmem_bad_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_addr  = {req_addr_q, 2'b00};
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Scoreboard bench for vscale_mem_arbiter: expected memory requests and DONE results
// are queued when a transaction is driven and checked as the DUT produces them.
module tb_vscale_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_wait, imem_badmem_e;
  logic        dmem_en, dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed, dmem_rdata;
  logic        dmem_wait, dmem_badmem_e;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  always #5 clk = ~clk;

  vscale_mem_arbiter #(.XPR_LEN(32), .MEM_BASE(32'h0), .MEM_SIZE(32'h10000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_wait(imem_wait),
    .imem_badmem_e(imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait),
    .dmem_badmem_e(dmem_badmem_e),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic [31:0] irdata;
    logic [31:0] drdata;
    logic        ibad;
    logic        dbad;
  } res_t;

  localparam logic [31:0] LIM = 32'h10000;

  req_t        req_q[$];
  res_t        res_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          stall_cnt = 0;
  int          acc_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h200) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] sz, input logic [31:0] w);
    logic [31:0] r;
    if (sz == 3'd0)      r = {w[7:0], w[7:0], w[7:0], w[7:0]};
    else if (sz == 3'd1) r = {w[15:0], w[15:0]};
    else                 r = w;
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd2) return 4'hf;
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Memory model: accepts on valid&ready, answers one cycle later, optional backpressure.
  initial begin
    req_t q;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend_data;
        pend = 1'b0;
      end else begin
        mem_resp_rdata = $urandom;
      end
      if (mem_req_valid && stall_cnt > 0) begin
        stall_cnt--;
        mem_req_ready = 1'b0;
        check("bp_wait", 32'(dmem_wait), 32'd1);
        if (req_q.size() > 0) begin
          check("bp_addr", mem_req_addr, req_q[0].addr);
          if (req_q[0].wen) check("bp_wdata", mem_req_wdata, req_q[0].wdata);
        end
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        acc_cnt++;
        check("req_expected", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          q = req_q.pop_front();
          check("req_addr", mem_req_addr, q.addr);
          check("req_wen", 32'(mem_req_wen), 32'(q.wen));
          check("req_wmask", 32'(mem_req_wmask), 32'(q.wmask));
          if (q.wen) check("req_wdata", mem_req_wdata, q.wdata);
        end
        pend      = 1'b1;
        pend_data = mem_rd(mem_req_addr);
      end
    end
  end

  // Call just before a capture edge (IDLE or DONE); returns at the DONE negedge.
  task automatic do_txn(input logic [31:0] ia, input logic den, input logic dwen,
                        input logic [2:0] sz, input logic [31:0] da, input logic [31:0] wd,
                        input int stall);
    logic ibad, dbad, dreq;
    req_t q;
    res_t r;
    int   lat, n;
    ibad = (ia >= LIM) || (ia[1:0] != 2'b00);
    dbad = den && ((da >= LIM) || (sz > 3'd2) || (sz == 3'd1 && da[0]) ||
                   (sz == 3'd2 && da[1:0] != 2'b00));
    dreq = den && !dbad;
    imem_addr = ia; dmem_en = den; dmem_wen = dwen; dmem_size = sz; dmem_addr = da;
    stall_cnt = stall;
    if (dreq) begin
      q.addr  = {da[31:2], 2'b00};
      q.wen   = dwen;
      q.wdata = dwen ? exp_wdata(sz, wd) : 32'h0;
      q.wmask = dwen ? exp_mask(sz, da) : 4'h0;
      req_q.push_back(q);
    end
    if (!ibad) begin
      q.addr = {ia[31:2], 2'b00}; q.wen = 1'b0; q.wdata = '0; q.wmask = 4'h0;
      req_q.push_back(q);
    end
    r.irdata = ibad ? 32'h0 : mem_rd({ia[31:2], 2'b00});
    r.drdata = (dreq && !dwen) ? mem_rd({da[31:2], 2'b00}) : 32'h0;
    r.ibad   = ibad;
    r.dbad   = dbad;
    res_q.push_back(r);
    lat = 1 + (dreq ? (dwen ? 3 : 2) : 0) + (!ibad ? 2 : 0) + ((dreq || !ibad) ? stall : 0);
    @(posedge clk);
    #1;
    dmem_wdata_delayed = wd;
    imem_addr = $urandom; dmem_addr = $urandom; dmem_en = 1'($urandom);
    dmem_wen = 1'($urandom); dmem_size = 3'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) dmem_wdata_delayed = $urandom;
      if (imem_wait) check("dwait_hi", 32'(dmem_wait), 32'd1);
    end while (imem_wait && n < 60);
    check("latency", 32'(n), 32'(lat));
    check("dwait_lo", 32'(dmem_wait), 32'd0);
    r = res_q.pop_front();
    check("imem_rdata", imem_rdata, r.irdata);
    check("dmem_rdata", dmem_rdata, r.drdata);
    check("imem_bad", 32'(imem_badmem_e), 32'(r.ibad));
    check("dmem_bad", 32'(dmem_badmem_e), 32'(r.dbad));
  endtask

  initial begin
    req_t q;
    int   a0, n;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t q;
    int   a0, n;
    reset = 1'b1;
    imem_addr = 32'h200; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd2;
    dmem_addr = '0; dmem_wdata_delayed = '0;
    repeat (3) @(negedge clk);
    check("rst_iwait", 32'(imem_wait), 32'd0);
    check("rst_dwait", 32'(dmem_wait), 32'd0);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    check("rst_irdata", imem_rdata, 32'h00000013);
    check("rst_drdata", dmem_rdata, 32'h0);
    check("rst_ibad", 32'(imem_badmem_e), 32'd0);
    check("rst_dbad", 32'(dmem_badmem_e), 32'd0);
    #1 reset = 1'b0;

    do_txn(32'h200, 1'b0, 1'b0, 3'd2, 32'h0,      32'h0,        0); // fetch only
    do_txn(32'h204, 1'b1, 1'b0, 3'd2, 32'h1004,   32'h0,        0); // load + fetch
    do_txn(32'h208, 1'b1, 1'b1, 3'd0, 32'h1003,   32'h000000AB, 0); // byte store
    do_txn(32'h20c, 1'b1, 1'b0, 3'd1, 32'h1001,   32'h0,        0); // misaligned half
    do_txn(32'h210, 1'b1, 1'b0, 3'd2, 32'h2000,   32'h0,        4); // load backpressure
    do_txn(32'h214, 1'b1, 1'b1, 3'd1, 32'h1006,   32'h1234BEEF, 2); // half store stalled
    do_txn(32'h218, 1'b1, 1'b1, 3'd2, 32'h1008,   32'hCAFEF00D, 0); // word store
    do_txn(32'h21c, 1'b1, 1'b0, 3'd2, 32'h10000,  32'h0,        0); // data out of range
    do_txn(32'h220, 1'b1, 1'b0, 3'd3, 32'h1000,   32'h0,        0); // illegal size
    do_txn(32'h202, 1'b1, 1'b0, 3'd2, 32'h100,    32'h0,        0); // misaligned fetch
    do_txn(32'hFFFC, 1'b1, 1'b0, 3'd2, 32'hFFFC,  32'h0,        0); // top legal word
    do_txn(32'h10000, 1'b0, 1'b0, 3'd2, 32'h0,    32'h0,        0); // nothing legal
    do_txn(32'h10004, 1'b1, 1'b1, 3'd2, 32'h1010, 32'h55AA33CC, 0); // store, bad fetch
    do_txn(32'h224, 1'b0, 1'b1, 3'd3, 32'hFFFFFFFF, 32'h0,      0); // dmem_en=0 ignores rest
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ia, da;
      ia = {14'h0, 16'($urandom_range(0, 16'h3FFF)), 2'b00};
      if ($urandom_range(0, 5) == 0) ia = ia + 32'd1;
      da = $urandom_range(0, 32'h10003);
      do_txn(ia, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), da, $urandom,
             $urandom_range(0, 2));
    end

    // Reset in the middle of a fetch response.
    imem_addr = 32'h300; dmem_en = 1'b0;
    q.addr = 32'h300; q.wen = 1'b0; q.wdata = '0; q.wmask = 4'h0;
    req_q.push_back(q);
    @(posedge clk);
    a0 = acc_cnt;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (acc_cnt == a0 && n < 20);
    @(negedge clk); #1;
    check("iresp_wait", 32'(imem_wait), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_iwait", 32'(imem_wait), 32'd0);
    check("mid_rst_dwait", 32'(dmem_wait), 32'd0);
    check("mid_rst_irdata", imem_rdata, 32'h00000013);
    check("mid_rst_valid", 32'(mem_req_valid), 32'd0);
    #1 reset = 1'b0;
    do_txn(32'h304, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 0);

    check("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
